// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and transmitter on the serial link.
`timescale 1ns / 1ps
package uart_pkg;

  // Payload width of one 8N1 frame.
  localparam int unsigned DATA_BITS = 8;

  // Receiver state encoding.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int unsigned baud_div(input int unsigned clk, input int unsigned baud);
    return (clk + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous pin; resets to 1 (idle level of a UART line).
`timescale 1ns / 1ps
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the pin through two flops to settle metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/usart_rx.sv
// 8N1 asynchronous serial receiver: oversampled bit timer, 3-tap majority vote,
// LSB-first shift register, one-cycle valid / framing-error strobes.
`timescale 1ns / 1ps
module usart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 40_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic                 clkH,
  input  logic                 rst_n,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] Dout,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned MID = DIV / 2;
  localparam int unsigned CW  = $clog2(DIV);

  localparam logic [CW-1:0] CntMax   = CW'(DIV - 1);
  localparam logic [CW-1:0] CntMidM1 = CW'(MID - 1);
  localparam logic [CW-1:0] CntMid   = CW'(MID);
  localparam logic [CW-1:0] CntVote  = CW'(MID + 1);
  localparam logic [2:0]    LastBit  = 3'(DATA_BITS - 1);

  logic rxs;
  logic rxs_prev_q;
  logic [1:0] settle_q;

  rx_state_e state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0] samp_q, samp_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic rx_valid_q, rx_valid_d;
  logic frame_err_q, frame_err_d;

  logic fall_edge;
  logic at_vote;
  logic cnt_wrap;
  logic vote;
  logic [CW-1:0] bit_cnt_inc;

  uart_sync2 u_sync (
    .clk_i  (clkH),
    .rst_ni (rst_n),
    .d_i    (RXD),
    .q_o    (rxs)
  );

  // Edge-detect history and a short settle counter: the synchronizer resets to 1, so a line
  // already low at release would otherwise look like a fresh 1->0 edge.
  always_ff @(posedge clkH or negedge rst_n) begin
    if (!rst_n) begin
      rxs_prev_q <= 1'b1;
      settle_q   <= 2'd0;
    end else begin
      rxs_prev_q <= rxs;
      if (settle_q != 2'd3) begin
        settle_q <= settle_q + 2'd1;
      end
    end
  end

  // Timing and vote helpers.
  always_comb begin
    fall_edge   = (settle_q == 2'd3) && rxs_prev_q && !rxs;
    at_vote     = (bit_cnt_q == CntVote);
    cnt_wrap    = (bit_cnt_q == CntMax);
    bit_cnt_inc = cnt_wrap ? '0 : bit_cnt_q + CW'(1);
    // samp_q[1] taken at mid-1, samp_q[0] at mid, rxs is the mid+1 tap.
    vote        = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs) | (samp_q[0] & rxs);
  end

  // Receiver state register and datapath registers.
  always_ff @(posedge clkH or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      samp_q      <= '0;
      dout_q      <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      samp_q      <= samp_d;
      dout_q      <= dout_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic: decisions are taken at mid+1, once all three vote taps are in.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_inc;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    dout_d      = dout_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    if (bit_cnt_q == CntMidM1) begin
      samp_d[1] = rxs;
    end
    if (bit_cnt_q == CntMid) begin
      samp_d[0] = rxs;
    end

    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        bit_idx_d = '0;
        if (fall_edge) begin
          // The edge cycle itself is tick 0 of the start bit.
          bit_cnt_d = CW'(1);
          state_d   = StStart;
        end
      end

      StStart: begin
        if (at_vote) begin
          // Counter keeps running, so the next vote lands exactly DIV cycles later.
          state_d = vote ? StIdle : StData;
        end
      end

      StData: begin
        if (at_vote) begin
          shift_d   = {vote, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LastBit) begin
            state_d = StStop;
          end
        end
      end

      StStop: begin
        if (at_vote) begin
          if (vote) begin
            dout_d     = shift_q;
            rx_valid_d = 1'b1;
            state_d    = StIdle;
          end else begin
            frame_err_d = 1'b1;
            bit_cnt_d   = '0;
            state_d     = StBreak;
          end
        end
      end

      StBreak: begin
        // Require a full bit period of continuous idle before re-arming.
        if (!rxs) begin
          bit_cnt_d = '0;
        end else if (cnt_wrap) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign Dout      = dout_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_usart_rx.sv
// Scoreboard bench for usart_rx: stimulus pushes expected bytes / framing errors into a queue,
// a monitor pops and compares on every rx_valid or frame_err strobe.
`timescale 1ns / 1ps
module tb_usart_rx;

  // Scaled-down link: 1.6 MHz / 100 kbaud gives a 16-cycle bit; only the ratio matters.
  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned DIV      = 16;
  localparam real         CLK_NS   = 10.0;
  localparam real         BIT_NS   = 160.0;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] dout;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  exp_t       exp_q[$];
  logic [7:0] exp_dout = 8'h00;
  int         exp_valid = 0;
  int         exp_err = 0;
  int         valid_cnt = 0;
  int         err_cnt = 0;
  int         total = 0;
  int         bad = 0;

  usart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clkH      (clk),
    .rst_n     (rst_n),
    .RXD       (rxd),
    .Dout      (dout),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #(CLK_NS / 2.0) clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (rx_valid || frame_err)) begin
      check("pulse_exclusive", {31'b0, rx_valid & frame_err}, 32'd0);
      if (rx_valid) valid_cnt++;
      if (frame_err) err_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'b0, rx_valid, frame_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", {31'b0, frame_err}, {31'b0, e.err});
        check("event_dout", {24'b0, dout}, {24'b0, e.data});
      end
    end
  end

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back('{err: 1'b0, data: b});
    exp_dout = b;
    exp_valid++;
  endtask

  task automatic expect_ferr();
    exp_q.push_back('{err: 1'b1, data: exp_dout});
    exp_err++;
  endtask

  // Drive one frame; line is left at the stop-bit level so frames can run back to back.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input real bit_ns);
    rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_ns);
    end
    rxd = stop_bit;
    #(bit_ns);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 50 * DIV) begin
      @(negedge clk);
      n++;
    end
    check({name, "_queue"}, exp_q.size(), 32'd0);
    check({name, "_valid_cnt"}, valid_cnt, exp_valid);
    check({name, "_err_cnt"}, err_cnt, exp_err);
  endtask

  initial begin : watchdog
    #800_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation timeout");
  end

  initial begin : stim
    int  n;
    logic saw;
    real rates[2];
    logic [7:0] skew_bytes[3];
    rates[0] = 1.03;
    rates[1] = 0.97;
    skew_bytes[0] = 8'h00;
    skew_bytes[1] = 8'hFF;
    skew_bytes[2] = 8'h5A;

    // Reset state.
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_dout", {24'b0, dout}, 32'd0);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2 * DIV) @(posedge clk);

    // T1 single byte.
    expect_byte(8'h55);
    send_byte(8'h55, 1'b1, BIT_NS);
    #(2 * BIT_NS);
    drain("t1");
    check("t1_dout", {24'b0, dout}, 32'h55);

    // T2 back-to-back frames.
    expect_byte(8'hA5);
    expect_byte(8'h3C);
    send_byte(8'hA5, 1'b1, BIT_NS);
    send_byte(8'h3C, 1'b1, BIT_NS);
    #(2 * BIT_NS);
    drain("t2");
    check("t2_dout", {24'b0, dout}, 32'h3C);

    // T3 short low glitch, well under half a bit.
    @(posedge clk);
    rxd = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) rxd = 1'b1;
      if (busy) saw = 1'b1;
    end
    check("t3_busy_seen", {31'b0, saw}, 32'd1);
    n = 0;
    while (busy && n < 2 * DIV) begin
      @(negedge clk);
      n++;
    end
    check("t3_busy_clear", {31'b0, busy}, 32'd0);
    check("t3_clear_within_div", {31'b0, (n <= DIV)}, 32'd1);
    drain("t3");

    // T4 framing error, line held low, then a good byte.
    expect_ferr();
    send_byte(8'h81, 1'b0, BIT_NS);
    #(3 * BIT_NS);
    rxd = 1'b1;
    #(2 * BIT_NS);
    drain("t4a");
    check("t4_dout_hold", {24'b0, dout}, 32'h3C);
    expect_byte(8'h0F);
    send_byte(8'h0F, 1'b1, BIT_NS);
    #(2 * BIT_NS);
    drain("t4b");
    check("t4_dout", {24'b0, dout}, 32'h0F);

    // T5 reset in the middle of bit 4 of 0xFF.
    rxd = 1'b0;
    #(BIT_NS);
    rxd = 1'b1;
    #(4.5 * BIT_NS);
    check("t5_busy_pre", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_dout", {24'b0, dout}, 32'd0);
    check("t5_rst_valid", {31'b0, rx_valid}, 32'd0);
    check("t5_rst_ferr", {31'b0, frame_err}, 32'd0);
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    exp_dout = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #(6 * BIT_NS);

    // Line already low at release must not start a frame.
    rxd = 1'b0;
    #(BIT_NS);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      if (busy) saw = 1'b1;
    end
    check("t5_low_release_busy", {31'b0, saw}, 32'd0);
    rxd = 1'b1;
    #(2 * BIT_NS);
    drain("t5a");
    check("t5_dout_cleared", {24'b0, dout}, 32'd0);
    expect_byte(8'h12);
    send_byte(8'h12, 1'b1, BIT_NS);
    #(2 * BIT_NS);
    drain("t5b");
    check("t5_dout", {24'b0, dout}, 32'h12);

    // T6 +/-3% baud skew, back to back.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) expect_byte(skew_bytes[k]);
      for (int k = 0; k < 3; k++) send_byte(skew_bytes[k], 1'b1, BIT_NS / rates[r]);
      #(2 * BIT_NS);
      drain(r == 0 ? "t6_fast" : "t6_slow");
      check("t6_dout", {24'b0, dout}, 32'h5A);
    end

    // T7 every byte value, back to back.
    for (int v = 0; v < 256; v++) begin
      expect_byte(8'(v));
      send_byte(8'(v), 1'b1, BIT_NS);
    end
    #(2 * BIT_NS);
    drain("t7");
    check("t7_dout", {24'b0, dout}, 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
